boot_loader: RTL

//  Sits upstream of the processor top: streams a program into instruction memory, then sequences pipeline bring-up.

---
 rtl/processor_pkg.sv | 21 ++
 rtl/boot_reset_seq.sv | 54 +++++
 rtl/boot_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared types for the processor bring-up logic: loader state encoding and word width.
package processor_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    CHECK   = 3'd3,
    RELEASE = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_t;

  // True once the processor state elements are allowed out of reset.
  function automatic logic core_released(input state_t s);
    return (s == RELEASE) || (s == RUN);
  endfunction

endpackage

// File: rtl/boot_reset_seq.sv
// Reset/enable sequencer for pipeline bring-up: decodes the loader state into processor
// resets and pipeline enables, and times the RELEASE window.
module boot_reset_seq
  import processor_pkg::*;
#(
  parameter int RELEASE_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t state,
  output logic   rel_done,
  output logic   im_rst,
  output logic   core_rst,
  output logic   pipe_rst,
  output logic   pipe_en
);

  localparam int CW = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  logic [CW-1:0] rel_cnt;

  // Counts cycles spent in RELEASE; the loader moves to RUN on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_cnt <= '0;
    end else if ((state == RELEASE) && !rel_done) begin
      rel_cnt <= rel_cnt + CW'(1);
    end else begin
      rel_cnt <= '0;
    end
  end

  assign rel_done = (state == RELEASE) && (rel_cnt == REL_LAST);

  always_comb begin
    im_rst   = 1'b1;
    core_rst = 1'b1;
    pipe_rst = 1'b1;
    pipe_en  = 1'b0;
    // Instruction memory leaves reset as soon as loading starts so it can be written.
    if ((state == LOAD) || (state == CHECK) || core_released(state)) begin
      im_rst = 1'b0;
    end
    if (core_released(state)) begin
      core_rst = 1'b0;
      pipe_rst = 1'b0;
    end
    if (state == RUN) begin
      pipe_en = 1'b1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams a program into instruction memory, then sequences processor bring-up.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit wrapping-sum word before release.
module boot_loader
  import processor_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_DATA,
  input  logic              in_last,
  output logic              im_WE,
  output logic [ADDR_W-1:0] im_ADDR,
  output logic [WORD_W-1:0] im_DATA,
  output logic              pc_RESET,
  output logic              im_RESET,
  output logic              rb_RESET,
  output logic              tf_RESET,
  output logic              dm_RESET,
  output logic              reg_ifid_exmem_RESET,
  output logic              reg_exmem_wb_RESET,
  output logic              reg_ifid_exmem_ENABLE,
  output logic              reg_exmem_wb_ENABLE,
  output logic              done,
  output logic              error,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic              xfer;
  logic              rel_done;
  logic              im_rst;
  logic              core_rst;
  logic              pipe_rst;
  logic              pipe_en;

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  localparam state_t AFTER_LAST = CHECK;
`else
  localparam state_t AFTER_LAST = RELEASE;
`endif

  // Stream handshake: a word moves on a rising edge where in_valid && in_ready are both
  // high; in_ready depends only on state, never on in_valid, and in_DATA/in_last are
  // sampled on that same edge.
`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state == LOAD) || (state == CHECK);
`else
  assign in_ready = (state == LOAD);
`endif
  assign xfer = in_valid && in_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      count   <= '0;
      im_WE   <= 1'b0;
      im_ADDR <= '0;
      im_DATA <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum     <= '0;
`endif
    end else begin
      im_WE <= 1'b0;
      case (state)
        IDLE, RUN, ERROR: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          count <= '0;
`ifdef LOADER_CHECKSUM_EN
          sum   <= '0;
`endif
          state <= LOAD;
        end
        LOAD: begin
          if (xfer) begin
            im_WE   <= 1'b1;
            im_ADDR <= count;
            im_DATA <= in_DATA;
            count   <= count + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
            sum     <= sum + in_DATA;
`endif
            // Overflow is caught on the last legal address, so im_ADDR never wraps.
            if (in_last) begin
              state <= AFTER_LAST;
            end else if (count == LAST_ADDR) begin
              state <= ERROR;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) state <= (in_DATA == sum) ? RELEASE : ERROR;
        end
`endif
        RELEASE: begin
          if (rel_done) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  boot_reset_seq #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_reset_seq (
    .clk      (CLK),
    .rst      (RESET),
    .state    (state),
    .rel_done (rel_done),
    .im_rst   (im_rst),
    .core_rst (core_rst),
    .pipe_rst (pipe_rst),
    .pipe_en  (pipe_en)
  );

  // CLEAR and ERROR hold im/dm reset via the sequencer's default, wiping both memories.
  assign im_RESET              = im_rst;
  assign pc_RESET              = core_rst;
  assign rb_RESET              = core_rst;
  assign tf_RESET              = core_rst;
  assign dm_RESET              = core_rst;
  assign reg_ifid_exmem_RESET  = pipe_rst;
  assign reg_exmem_wb_RESET    = pipe_rst;
  assign reg_ifid_exmem_ENABLE = pipe_en;
  assign reg_exmem_wb_ENABLE   = pipe_en;
  assign done                  = (state == RUN);
  assign error                 = (state == ERROR);
  assign dbg_state             = state;

endmodule
